// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive path: default oversample ratio,
// data width, idle line level and the receiver state encodings.
// Optional feature macro (used by uart_receiver): UART_RX_FRAME_CHECK_EN
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int   UART_OVERSAMPLE = 16;
   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   localparam logic [2:0] UART_ST_IDLE  = 3'd0;
   localparam logic [2:0] UART_ST_START = 3'd1;
   localparam logic [2:0] UART_ST_DATA  = 3'd2;
   localparam logic [2:0] UART_ST_STOP  = 3'd3;
   localparam logic [2:0] UART_ST_BREAK = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = UART_ST_IDLE,
      ST_START = UART_ST_START,
      ST_DATA  = UART_ST_DATA,
      ST_STOP  = UART_ST_STOP,
      ST_BREAK = UART_ST_BREAK
   } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing the asynchronous serial pin into the
// baudclk domain. Both flops preset to the idle line level so a reset never
// looks like a start edge.
// Ports:
//   baudclk  in  sample clock
//   reset    in  asynchronous, active-low
//   i_rx     in  raw serial line
//   o_rx_s   out synchronized serial line
// ---------------------------------------------------------------------------
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic baudclk,
   input  logic reset,
   input  logic i_rx,
   output logic o_rx_s
);

   logic [1:0] r_sync;

   always_ff @(posedge baudclk or negedge reset) begin
      if (!reset) r_sync <= {2{UART_IDLE_LEVEL}};
      else        r_sync <= {r_sync[0], i_rx};
   end

   assign o_rx_s = r_sync[1];

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receive path, LSB first, idle high. Oversamples the line at
// OVERSAMPLE x bit rate, samples each bit at its centre and presents the
// recovered byte with a one-cycle strobe.
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined   : a low stop sample raises RX_FERR for one cycle, leaves
//               RX_DATA alone and parks in BREAK until the line goes high.
//   undefined : a low stop sample is accepted as a good stop; RX_FERR = 0.
// Ports:
//   baudclk    in  sample clock, OVERSAMPLE x bit rate
//   reset      in  asynchronous, active-low
//   UART_RX    in  serial line (asynchronous)
//   RX_DATA    out last good byte, held until the next good frame
//   RX_STATUS  out one-cycle strobe, RX_DATA just updated
//   RX_BUSY    out high whenever the receiver is not idle
//   RX_FERR    out one-cycle framing error strobe
// ---------------------------------------------------------------------------
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 baudclk,
   input  logic                 reset,
   input  logic                 UART_RX,
   output logic [DATA_BITS-1:0] RX_DATA,
   output logic                 RX_STATUS,
   output logic                 RX_BUSY,
   output logic                 RX_FERR
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   uart_state_t          r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bitidx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_status;
   logic                 w_rx_s;
`ifdef UART_RX_FRAME_CHECK_EN
   logic                 r_ferr;
`endif

   uart_rx_sync u_sync (
      .baudclk (baudclk),
      .reset   (reset),
      .i_rx    (UART_RX),
      .o_rx_s  (w_rx_s)
   );

   always_ff @(posedge baudclk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_bitidx <= '0;
         r_shift  <= '0;
         r_data   <= '0;
         r_status <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
         r_ferr   <= 1'b0;
`endif
      end else begin
         r_status <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
         r_ferr   <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (!w_rx_s) r_state <= ST_START;
            end
            // Half a bit in: confirm the start bit, then resync the
            // counter so later samples land on bit centres.
            ST_START: begin
               if (r_cnt == CNT_MID) begin
                  r_cnt    <= '0;
                  r_bitidx <= '0;
                  r_state  <= w_rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_END) begin
                  r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  if (r_bitidx == BIT_LAST) r_state  <= ST_STOP;
                  else                      r_bitidx <= r_bitidx + 1'b1;
               end
            end
            // Leaving at mid stop bit gives half a bit of slack to catch
            // a back-to-back start edge.
            ST_STOP: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_END) begin
`ifdef UART_RX_FRAME_CHECK_EN
                  if (w_rx_s) begin
                     r_data   <= r_shift;
                     r_status <= 1'b1;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_ferr   <= 1'b1;
                     r_state  <= ST_BREAK;
                  end
`else
                  r_data   <= r_shift;
                  r_status <= 1'b1;
                  r_state  <= ST_IDLE;
`endif
               end
            end
`ifdef UART_RX_FRAME_CHECK_EN
            // Line stuck low after a bad stop: wait for it to recover.
            ST_BREAK: begin
               r_cnt <= '0;
               if (w_rx_s) r_state <= ST_IDLE;
            end
`endif
            default: begin
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign RX_DATA   = r_data;
   assign RX_STATUS = r_status;
   assign RX_BUSY   = (r_state != ST_IDLE);
`ifdef UART_RX_FRAME_CHECK_EN
   assign RX_FERR   = r_ferr;
`else
   assign RX_FERR   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Directed frames at 16x oversample against hand-computed bytes and timing.
// Inputs change on falling edges; outputs are observed on falling edges.
// Edge index 0 is the first rising edge that samples the start bit low.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

   logic       baudclk = 1'b0;
   logic       reset   = 1'b0;
   logic       UART_RX = 1'b1;
   logic [7:0] RX_DATA;
   logic       RX_STATUS;
   logic       RX_BUSY;
   logic       RX_FERR;

   int nvec = 0, nmis = 0;
   int cyc = 0;
   int n_stb = 0, n_ferr = 0, n_both = 0;
   int last_stb = 0, prev_stb = 0;
   int busy_err = 0;

   uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .baudclk   (baudclk),
      .reset     (reset),
      .UART_RX   (UART_RX),
      .RX_DATA   (RX_DATA),
      .RX_STATUS (RX_STATUS),
      .RX_BUSY   (RX_BUSY),
      .RX_FERR   (RX_FERR)
   );

   always #5 baudclk = ~baudclk;

   always @(posedge baudclk) cyc <= cyc + 1;

   // strobe monitor
   always @(negedge baudclk) begin
      if (RX_STATUS) begin
         prev_stb = last_stb;
         last_stb = cyc;
         n_stb++;
      end
      if (RX_FERR) n_ferr++;
      if (RX_STATUS && RX_FERR) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      UART_RX = 1'b1;
      repeat (n) @(negedge baudclk);
   endtask

   // Must be called right after a falling edge. Returns the cyc value of
   // edge 0; flags RX_BUSY low anywhere between edge 2 and edge 153.
   task automatic send_frame(input logic [7:0] d, input logic stopb, output int t0);
      logic [9:0] fr;
      fr = {stopb, d, 1'b0};
      t0 = cyc + 1;
      for (int b = 0; b < 10; b++) begin
         UART_RX = fr[b];
         repeat (16) begin
            @(negedge baudclk);
            if ((cyc - t0) >= 2 && (cyc - t0) <= 153 && !RX_BUSY) busy_err++;
         end
      end
   endtask

   initial begin
      int t0, t1, s0, f0;
      logic [9:0] fr;

      // reset state
      reset = 1'b0; UART_RX = 1'b1;
      repeat (3) @(negedge baudclk);
      chk("rst_data",   RX_DATA,   32'h00);
      chk("rst_status", RX_STATUS, 32'h0);
      chk("rst_busy",   RX_BUSY,   32'h0);
      chk("rst_ferr",   RX_FERR,   32'h0);
      reset = 1'b1;
      idle(20);

      // single frame 0xA5, strobe visible right after edge 154
      s0 = n_stb; busy_err = 0;
      send_frame(8'hA5, 1'b1, t0);
      idle(4);
      chk("a5_data",  RX_DATA,        32'hA5);
      chk("a5_nstb",  n_stb - s0,     32'd1);
      chk("a5_lat",   last_stb - t0,  32'd154);
      chk("a5_busy",  busy_err,       32'd0);
      chk("a5_idle",  RX_BUSY,        32'h0);

      // back-to-back 0x55, 0x3C with no gap
      s0 = n_stb;
      send_frame(8'h55, 1'b1, t0);
      chk("b2b_d0",   RX_DATA,        32'h55);
      send_frame(8'h3C, 1'b1, t1);
      idle(4);
      chk("b2b_d1",   RX_DATA,        32'h3C);
      chk("b2b_nstb", n_stb - s0,     32'd2);
      chk("b2b_gap",  last_stb - prev_stb, 32'd160);

      // 3-cycle glitch: START entered after edge 2, rejected at edge 10
      idle(20);
      s0 = n_stb;
      UART_RX = 1'b0;
      repeat (3) @(negedge baudclk);
      UART_RX = 1'b1;
      chk("gl_start", RX_BUSY,        32'h1);
      repeat (8) @(negedge baudclk);
      chk("gl_idle",  RX_BUSY,        32'h0);
      idle(40);
      chk("gl_nstb",  n_stb - s0,     32'd0);
      chk("gl_data",  RX_DATA,        32'h3C);

      // 0xFF with a low stop bit, line held low 40 more cycles
      s0 = n_stb; f0 = n_ferr; busy_err = 0;
      send_frame(8'hFF, 1'b0, t0);
      repeat (40) @(negedge baudclk);
`ifdef UART_RX_FRAME_CHECK_EN
      chk("fe_ferr",  n_ferr - f0,    32'd1);
      chk("fe_nstb",  n_stb - s0,     32'd0);
      chk("fe_data",  RX_DATA,        32'h3C);
      chk("fe_break", RX_BUSY,        32'h1);
      UART_RX = 1'b1;
      repeat (4) @(negedge baudclk);
      chk("fe_recov", RX_BUSY,        32'h0);
      idle(20);
`else
      chk("fe_nstb",  n_stb - s0,     32'd1);
      chk("fe_data",  RX_DATA,        32'hFF);
      chk("fe_ferr",  n_ferr - f0,    32'd0);
      // the long low is seen as a further start; let that frame drain
      idle(250);
`endif

      // reset in the middle of data bit 4 of 0x3C
      fr = {1'b1, 8'h3C, 1'b0};
      for (int b = 0; b < 5; b++) begin
         UART_RX = fr[b];
         repeat (16) @(negedge baudclk);
      end
      UART_RX = fr[5];
      repeat (8) @(negedge baudclk);
      chk("mr_pre_busy", RX_BUSY,     32'h1);
      reset = 1'b0;
      #1;
      chk("mr_data",   RX_DATA,       32'h00);
      chk("mr_status", RX_STATUS,     32'h0);
      chk("mr_busy",   RX_BUSY,       32'h0);
      chk("mr_ferr",   RX_FERR,       32'h0);
      UART_RX = 1'b1;
      repeat (5) @(negedge baudclk);
      reset = 1'b1;
      idle(20);
      s0 = n_stb;
      send_frame(8'h81, 1'b1, t0);
      idle(4);
      chk("mr_next",   RX_DATA,       32'h81);
      chk("mr_nstb",   n_stb - s0,    32'd1);

      // 0x00 then 0xFF with two idle bits between
      s0 = n_stb; f0 = n_ferr;
      send_frame(8'h00, 1'b1, t0);
      chk("gap_d0",    RX_DATA,       32'h00);
      idle(32);
      send_frame(8'hFF, 1'b1, t1);
      idle(4);
      chk("gap_d1",    RX_DATA,       32'hFF);
      chk("gap_nstb",  n_stb - s0,    32'd2);
      chk("gap_ferr",  n_ferr - f0,   32'd0);
      chk("both_hi",   n_both,        32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
